// File: rtl/tbb_pingpong.sv
// tbb_pingpong: double-buffered batch buffer between the host line request /
// response path and one PE array. One bank fills from the host while the PE
// array works on the other. Banks are handed to the PE array in fill order.
//
// Ports:
//   clk, reset          core clock, asynchronous active-high reset
//   fill_en             permits starting a new bank fill
//   batch_lines         length of the next batch, sampled when a fill starts
//   ReqValid/ReqLineIdx line request to the host; ReqAck accepts it
//   WrEn/WrAddr/WrDin   response line write (any order)
//   task_start          one-cycle pulse when a bank is handed to the PE array
//   task_bank/task_lines bank and batch length of the current task
//   task_done           PE array finished the current bank
//   RdAddr/RdDout       word read from the processing bank, 1-cycle latency
//   Full/Empty          no bank empty / both banks empty
//   wr_err              sticky: a response write arrived outside a fill
module tbb_pingpong #(
  parameter int LINE_ADDR_WIDTH = 6,
  parameter int LINE_WIDTH      = 512,
  parameter int WORD_WIDTH      = 32,
  parameter int WORDS_LOG2      = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  fill_en,
  input  logic [LINE_ADDR_WIDTH:0]              batch_lines,
  output logic                                  ReqValid,
  output logic [LINE_ADDR_WIDTH-1:0]            ReqLineIdx,
  input  logic                                  ReqAck,
  input  logic                                  WrEn,
  input  logic [LINE_ADDR_WIDTH-1:0]            WrAddr,
  input  logic [LINE_WIDTH-1:0]                 WrDin,
  output logic                                  task_start,
  output logic                                  task_bank,
  output logic [LINE_ADDR_WIDTH:0]              task_lines,
  input  logic                                  task_done,
  input  logic [LINE_ADDR_WIDTH+WORDS_LOG2-1:0] RdAddr,
  output logic [WORD_WIDTH-1:0]                 RdDout,
  output logic                                  Full,
  output logic                                  Empty,
  output logic                                  wr_err
);

  localparam int NUM_LINES = 1 << LINE_ADDR_WIDTH;
  localparam int NUM_WORDS = 1 << WORDS_LOG2;
  localparam int LEN_W     = LINE_ADDR_WIDTH + 1;
  localparam int RA_W      = LINE_ADDR_WIDTH + WORDS_LOG2;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(NUM_LINES);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_BUSY} bank_state_t;
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} fill_state_t;
  typedef enum logic {E_IDLE, E_BUSY} exec_state_t;

  // Zero or oversized lengths mean a full bank.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] n);
    if (n == '0 || n > LEN_MAX) return LEN_MAX;
    return n;
  endfunction

  fill_state_t        f_state, f_next;
  exec_state_t        e_state, e_next;
  bank_state_t        bank_st  [2];
  logic [LEN_W-1:0]   bank_len [2];
  logic               fill_sel, exec_sel;
  logic [LEN_W-1:0]   req_cnt, wr_cnt, fill_len;
  logic               task_bank_q;
  logic [LEN_W-1:0]   task_lines_q;
  logic               fill_start, fill_done, req_acc, wr_acc, exec_free;

  // Fill FSM: next state and strobes
  always_comb begin
    f_next     = f_state;
    fill_start = 1'b0;
    fill_done  = 1'b0;
    req_acc    = 1'b0;
    ReqValid   = 1'b0;
    case (f_state)
      F_IDLE: begin
        if (fill_en && bank_st[fill_sel] == B_EMPTY) begin
          fill_start = 1'b1;
          f_next     = F_REQ;
        end
      end
      F_REQ: begin
        ReqValid = 1'b1;
        if (ReqAck) begin
          req_acc = 1'b1;
          if (req_cnt == fill_len - LEN_ONE) f_next = F_WAIT;
        end
      end
      F_WAIT: begin
        if (wr_cnt == fill_len) begin
          fill_done = 1'b1;
          f_next    = F_IDLE;
        end
      end
      default: f_next = F_IDLE;
    endcase
  end

  assign wr_acc     = WrEn && (f_state == F_REQ || f_state == F_WAIT);
  assign ReqLineIdx = req_cnt[LINE_ADDR_WIDTH-1:0];

  // Exec FSM: next state and strobes
  always_comb begin
    e_next     = e_state;
    task_start = 1'b0;
    exec_free  = 1'b0;
    case (e_state)
      E_IDLE: begin
        if (bank_st[exec_sel] == B_FULL) begin
          task_start = 1'b1;
          e_next     = E_BUSY;
        end
      end
      E_BUSY: begin
        if (task_done) begin
          exec_free = 1'b1;
          e_next    = E_IDLE;
        end
      end
    endcase
  end

  // Task descriptor is visible in the start cycle itself, then held.
  assign task_bank  = task_start ? exec_sel : task_bank_q;
  assign task_lines = task_start ? bank_len[exec_sel] : task_lines_q;

  assign Full  = (bank_st[0] != B_EMPTY) && (bank_st[1] != B_EMPTY);
  assign Empty = (bank_st[0] == B_EMPTY) && (bank_st[1] == B_EMPTY);

  // Fill and exec touch different banks at any time (fill owns EMPTY/FILLING,
  // exec owns FULL/BUSY), so both updates can land in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_state      <= F_IDLE;
      e_state      <= E_IDLE;
      fill_sel     <= 1'b0;
      exec_sel     <= 1'b0;
      req_cnt      <= '0;
      wr_cnt       <= '0;
      fill_len     <= '0;
      bank_st[0]   <= B_EMPTY;
      bank_st[1]   <= B_EMPTY;
      bank_len[0]  <= '0;
      bank_len[1]  <= '0;
      task_bank_q  <= 1'b0;
      task_lines_q <= '0;
      wr_err       <= 1'b0;
    end else begin
      f_state <= f_next;
      e_state <= e_next;
      if (fill_start) begin
        fill_len           <= clamp_len(batch_lines);
        bank_len[fill_sel] <= clamp_len(batch_lines);
        bank_st[fill_sel]  <= B_FILLING;
        req_cnt            <= '0;
        wr_cnt             <= '0;
      end
      if (req_acc) req_cnt <= req_cnt + LEN_ONE;
      if (wr_acc)  wr_cnt  <= wr_cnt + LEN_ONE;
      if (fill_done) begin
        bank_st[fill_sel] <= B_FULL;
        fill_sel          <= ~fill_sel;
      end
      if (WrEn && f_state == F_IDLE) wr_err <= 1'b1;
      if (task_start) begin
        bank_st[exec_sel] <= B_BUSY;
        task_bank_q       <= exec_sel;
        task_lines_q      <= bank_len[exec_sel];
      end
      if (exec_free) begin
        bank_st[exec_sel] <= B_EMPTY;
        exec_sel          <= ~exec_sel;
      end
    end
  end

  // Line storage, both banks in one array indexed {bank, line}.
  logic [LINE_WIDTH-1:0] mem [2*NUM_LINES];
  logic [LINE_WIDTH-1:0] rd_line_p1;
  logic [WORDS_LOG2-1:0] wsel_p1;
  logic                  rd_vld_p1;
  logic [WORD_WIDTH-1:0] rd_words_p1 [NUM_WORDS];

  // Stage p0 -> p1: line read and word index register
  always_ff @(posedge clk) begin
    if (wr_acc) mem[{fill_sel, WrAddr}] <= WrDin;
    rd_line_p1 <= mem[{exec_sel, RdAddr[RA_W-1:WORDS_LOG2]}];
    wsel_p1    <= RdAddr[WORDS_LOG2-1:0];
  end

  // Masks the unreset read register until one read has completed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_vld_p1 <= 1'b0;
    else       rd_vld_p1 <= 1'b1;
  end

  // Stage p1: word select
  always_comb begin
    for (int k = 0; k < NUM_WORDS; k++) begin
      rd_words_p1[k] = rd_line_p1[k*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  assign RdDout = rd_vld_p1 ? rd_words_p1[wsel_p1] : '0;

endmodule
